// File: rtl/sync_fifo_flags_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sync_fifo_flags_if : producer/consumer bundle for sync_fifo_flags |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface sync_fifo_flags_if #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_SIZE = 4
);
  logic                  wr_en;
  logic                  rd_en;
  logic [WIDTH-1:0]      fifo_in;
  logic                  err_clr;
  logic [WIDTH-1:0]      fifo_out;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_almost_full;
  logic                  fifo_almost_empty;
  logic                  fifo_overflow;
  logic                  fifo_underflow;
  logic [DEPTH_SIZE:0]   fifo_counter;

  modport master (
    output wr_en, rd_en, fifo_in, err_clr,
    input  fifo_out, fifo_full, fifo_empty, fifo_almost_full,
           fifo_almost_empty, fifo_overflow, fifo_underflow, fifo_counter
  );

  modport slave (
    input  wr_en, rd_en, fifo_in, err_clr,
    output fifo_out, fifo_full, fifo_empty, fifo_almost_full,
           fifo_almost_empty, fifo_overflow, fifo_underflow, fifo_counter
  );
endinterface
`default_nettype wire

// File: rtl/sync_fifo_flags.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sync_fifo_flags : single-clock FIFO, FWFT option, sticky errors   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module sync_fifo_flags #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_SIZE = 4,
  parameter int FWFT       = 0,
  parameter int AF_THRESH  = 12,
  parameter int AE_THRESH  = 2
) (
  input  wire logic          Clk,
  input  wire logic          Rst,
  sync_fifo_flags_if.slave   bus
);
  localparam int                DEPTH = 1 << DEPTH_SIZE;
  localparam logic [DEPTH_SIZE:0] c_DEPTH = (DEPTH_SIZE+1)'(DEPTH);
  localparam logic [DEPTH_SIZE:0] c_AF    = (DEPTH_SIZE+1)'(AF_THRESH);
  localparam logic [DEPTH_SIZE:0] c_AE    = (DEPTH_SIZE+1)'(AE_THRESH);

  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [DEPTH_SIZE-1:0] r_wr_ptr;
  logic [DEPTH_SIZE-1:0] r_rd_ptr;
  logic [DEPTH_SIZE:0]   r_count;
  logic                  r_overflow;
  logic                  r_underflow;

  logic w_full;
  logic w_empty;
  logic w_rd_acc;
  logic w_wr_acc;

  assign w_full   = (r_count == c_DEPTH);
  assign w_empty  = (r_count == '0);
  assign w_rd_acc = bus.rd_en && !w_empty;
  // A full FIFO still takes a write when a read frees a slot on the same edge.
  assign w_wr_acc = bus.wr_en && (!w_full || w_rd_acc);

  always_ff @(posedge Clk) begin
    if (!Rst && w_wr_acc) begin
      r_mem[r_wr_ptr] <= bus.fifo_in;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_wr_acc && !w_rd_acc) begin
        r_count <= r_count + 1'b1;
      end else if (w_rd_acc && !w_wr_acc) begin
        r_count <= r_count - 1'b1;
      end
      // New errors take priority over a coincident clear.
      if (bus.wr_en && !w_wr_acc) begin
        r_overflow <= 1'b1;
      end else if (bus.err_clr) begin
        r_overflow <= 1'b0;
      end
      if (bus.rd_en && !w_rd_acc) begin
        r_underflow <= 1'b1;
      end else if (bus.err_clr) begin
        r_underflow <= 1'b0;
      end
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is shown directly; forced to zero while nothing is stored.
      assign bus.fifo_out = w_empty ? '0 : r_mem[r_rd_ptr];
    end else begin : g_regout
      logic [WIDTH-1:0] r_dout;
      always_ff @(posedge Clk) begin
        if (Rst) begin
          r_dout <= '0;
        end else if (w_rd_acc) begin
          r_dout <= r_mem[r_rd_ptr];
        end
      end
      assign bus.fifo_out = r_dout;
    end
  endgenerate

  assign bus.fifo_full         = w_full;
  assign bus.fifo_empty        = w_empty;
  assign bus.fifo_almost_full  = (r_count >= c_AF);
  assign bus.fifo_almost_empty = (r_count <= c_AE);
  assign bus.fifo_overflow     = r_overflow;
  assign bus.fifo_underflow    = r_underflow;
  assign bus.fifo_counter      = r_count;
endmodule
`default_nettype wire
